// File: rtl/onehot_dec_pkg.sv
// rtl/onehot_dec_pkg.sv - shared types, mode constants and one-hot helper for the scan decoder
package onehot_dec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest decode the helper supports; callers cast the result down to their OUT_W.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_OUT_W-1:0] r;
        r      = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational binary-to-one-hot decode of SEL_W bits into 1<<SEL_W lines
module onehot_dec
    import onehot_dec_pkg::*;
#(
    parameter int   SEL_W = 3,
    localparam int  OUT_W = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] out
);

    assign out = OUT_W'(onehot(MAX_SEL_W'(sel)));

endmodule

// File: rtl/onehot_scan_decoder.sv
// rtl/onehot_scan_decoder.sv - registered one-hot decoder with direct and wrapping scan modes
module onehot_scan_decoder
    import onehot_dec_pkg::*;
#(
    parameter int   SEL_W  = 3,
    parameter int   HOLD_W = 8,
    localparam int  OUT_W  = 1 << SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [HOLD_W-1:0] hold,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [SEL_W:0] LAST_STEP = (SEL_W+1)'(OUT_W - 1);

    state_e              state_q, state_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [HOLD_W-1:0]   hold_cfg_q, hold_cfg_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SEL_W:0]      step_cnt_q, step_cnt_d;

    logic                accept;
    logic [SEL_W-1:0]    idx_next;
    logic [OUT_W-1:0]    accept_dec;
    logic [OUT_W-1:0]    step_dec;

    assign in_ready = en & (state_q == IDLE) & ~abort;
    assign accept   = in_valid & in_ready;
    assign idx_next = idx_q + SEL_W'(1);

    onehot_dec #(.SEL_W(SEL_W)) u_accept_dec (
        .sel (sel),
        .out (accept_dec)
    );

    onehot_dec #(.SEL_W(SEL_W)) u_step_dec (
        .sel (idx_next),
        .out (step_dec)
    );

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        idx_d       = idx_q;
        hold_cfg_d  = hold_cfg_q;
        hold_cnt_d  = hold_cnt_q;
        step_cnt_d  = step_cnt_q;

        if (abort) begin
            state_d    = IDLE;
            out_d      = '0;
            idx_d      = '0;
            hold_cfg_d = '0;
            hold_cnt_d = '0;
            step_cnt_d = '0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        out_d       = accept_dec;
                        out_valid_d = 1'b1;
                        if (mode == MODE_SCAN) begin
                            state_d    = SCAN;
                            idx_d      = sel;
                            hold_cfg_d = hold;
                            hold_cnt_d = '0;
                            step_cnt_d = '0;
                        end
                    end
                end
                SCAN: begin
                    if (hold_cnt_q == hold_cfg_q) begin
                        hold_cnt_d = '0;
                        // The final position has now been held its full length: finish on this edge.
                        if (step_cnt_q == LAST_STEP) begin
                            state_d    = IDLE;
                            out_d      = '0;
                            done_d     = 1'b1;
                            idx_d      = '0;
                            step_cnt_d = '0;
                        end else begin
                            idx_d       = idx_next;
                            out_d       = step_dec;
                            out_valid_d = 1'b1;
                            step_cnt_d  = step_cnt_q + (SEL_W+1)'(1);
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    out_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= '0;
            hold_cfg_q  <= '0;
            hold_cnt_q  <= '0;
            step_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            hold_cfg_q  <= hold_cfg_d;
            hold_cnt_q  <= hold_cnt_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q == SCAN);

endmodule
